// File: rtl/timer_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_seq_pkg
// Description : Shared types and constants for the APB timer sequencer:
//               sequencer state encoding, timer control-register bit
//               positions and the status-register event flag mask.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_seq_pkg;

  // Sequencer states. The values are fixed so a state can be read
  // directly off a waveform.
  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_WR_TDR     = 4'd1,
    ST_WR_TCR_LD  = 4'd2,
    ST_WR_TCR_RUN = 4'd3,
    ST_POLL       = 4'd4,
    ST_CLR        = 4'd5,
    ST_WR_TCR_OFF = 4'd6,
    ST_DONE       = 4'd7,
    ST_ERR        = 4'd8
  } seq_state_t;

  // Timer control register bit positions
  localparam int C_TCR_LOAD_BIT = 7;
  localparam int C_TCR_DOWN_BIT = 5;
  localparam int C_TCR_EN_BIT   = 4;

  // Status register: bit0 = overflow, bit1 = underflow
  localparam logic [7:0] C_TSR_FLAG_MASK = 8'h03;

  // One-hot mask for a control register bit
  function automatic logic [7:0] tcr_mask(input int unsigned pos);
    tcr_mask = 8'h01 << pos;
  endfunction

endpackage : timer_seq_pkg
`default_nettype wire

// File: rtl/timer_apb_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : timer_apb_sequencer_if
// Description : APB bus bundle between the sequencer (master) and the
//               timer's APB slave port. 8-bit address and data.
//               master : drives M_PSEL/M_PENABLE/M_PWRITE/M_PADDR/M_PWDATA,
//                        receives M_PRDATA/M_PREADY/M_PSLVERR
//               slave  : the mirror image
// Revision    : 1.0 - initial release
// ============================================================================
interface timer_apb_sequencer_if;
  import timer_seq_pkg::*;

  logic       M_PSEL;
  logic       M_PENABLE;
  logic       M_PWRITE;
  logic [7:0] M_PADDR;
  logic [7:0] M_PWDATA;
  logic [7:0] M_PRDATA;
  logic       M_PREADY;
  logic       M_PSLVERR;

  modport master (
    output M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA,
    input  M_PRDATA, M_PREADY, M_PSLVERR
  );

  modport slave (
    input  M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA,
    output M_PRDATA, M_PREADY, M_PSLVERR
  );

endinterface : timer_apb_sequencer_if
`default_nettype wire

// File: rtl/apb_master_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_if
// Description : Single-transfer APB master engine. A one-cycle 'req' with
//               addr/wdata/write launches a transfer whose SETUP phase is
//               the following cycle. 'ack' marks the completing ACCESS
//               cycle (PENABLE & PREADY); rdata/slverr are valid only then.
//               A new 'req' in the ack cycle chains the next transfer with
//               no idle cycle between them.
//               Optional wait limit compiled in by TIMER_SEQ_TIMEOUT_EN:
//               after TO_CYCLES ACCESS cycles without PREADY the transfer
//               is dropped and 'timeout' pulses.
// Ports       : PCLK, PRESETn (sync, active-low)
//               req, addr[7:0], wdata[7:0], write  - transfer request
//               ack, rdata[7:0], slverr, timeout   - transfer result
//               bus                                - APB master modport
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_if
  import timer_seq_pkg::*;
#(
  parameter int TO_CYCLES = 16
) (
  input  wire logic       PCLK,
  input  wire logic       PRESETn,
  input  wire logic       req,
  input  wire logic [7:0] addr,
  input  wire logic [7:0] wdata,
  input  wire logic       write,
  output logic            ack,
  output logic [7:0]      rdata,
  output logic            slverr,
  output logic            timeout,
  timer_apb_sequencer_if.master bus
);

  logic       r_psel;
  logic       r_penable;
  logic       r_pwrite;
  logic [7:0] r_paddr;
  logic [7:0] r_pwdata;

  assign ack    = r_psel & r_penable & bus.M_PREADY;
  assign rdata  = bus.M_PRDATA;
  assign slverr = ack & bus.M_PSLVERR;

`ifdef TIMER_SEQ_TIMEOUT_EN
  // Counts ACCESS cycles spent waiting; zero outside ACCESS so every
  // transfer starts from a fresh budget.
  logic [15:0] r_wait_cnt;

  assign timeout = r_psel & r_penable & ~bus.M_PREADY &
                   (r_wait_cnt == 16'(TO_CYCLES - 1));

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_wait_cnt <= 16'd0;
    end else if (!r_penable || ack || timeout) begin
      r_wait_cnt <= 16'd0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end
`else
  assign timeout = 1'b0;
  logic [15:0] w_unused_to;
  assign w_unused_to = 16'(TO_CYCLES);
`endif

  // Address, data and direction are captured only at launch, so they stay
  // stable through SETUP and ACCESS and hold their value afterwards.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= 8'h00;
      r_pwdata  <= 8'h00;
    end else if (req) begin
      r_psel    <= 1'b1;
      r_penable <= 1'b0;
      r_pwrite  <= write;
      r_paddr   <= addr;
      r_pwdata  <= wdata;
    end else if (r_psel && !r_penable) begin
      r_penable <= 1'b1;
    end else if (ack || timeout) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
    end
  end

  assign bus.M_PSEL    = r_psel;
  assign bus.M_PENABLE = r_penable;
  assign bus.M_PWRITE  = r_pwrite;
  assign bus.M_PADDR   = r_paddr;
  assign bus.M_PWDATA  = r_pwdata;

endmodule : apb_master_if
`default_nettype wire

// File: rtl/timer_apb_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : timer_apb_sequencer
// Description : APB master that runs the 8-bit APB timer autonomously:
//               loads TDR, loads then starts TCR, polls TSR for
//               overflow/underflow, clears TSR per event, counts events and
//               switches the timer off after num_events events (or on stop).
//               Optional macro: TIMER_SEQ_TIMEOUT_EN (PREADY wait limit of
//               TO_CYCLES ACCESS cycles, then error).
// Ports       : PCLK, PRESETn (sync, active-low)
//               start, stop              - control pulses
//               cfg_tdr, cfg_tcr         - reload / control value (at start)
//               num_events               - auto-stop count, 0 = until stop
//               busy, done, event_pulse, event_count, err - status
//               m_apb                    - APB master (M_P* signals)
// Revision    : 1.0 - initial release
// ============================================================================
module timer_apb_sequencer
  import timer_seq_pkg::*;
#(
  parameter logic [7:0] TCR_ADDR  = 8'h00,
  parameter logic [7:0] TSR_ADDR  = 8'h01,
  parameter logic [7:0] TDR_ADDR  = 8'h02,
  parameter int         TO_CYCLES = 16
) (
  input  wire logic       PCLK,
  input  wire logic       PRESETn,
  input  wire logic       start,
  input  wire logic       stop,
  input  wire logic [7:0] cfg_tdr,
  input  wire logic [7:0] cfg_tcr,
  input  wire logic [7:0] num_events,
  output logic            busy,
  output logic            done,
  output logic            event_pulse,
  output logic [7:0]      event_count,
  output logic            err,
  timer_apb_sequencer_if.master m_apb
);

  localparam logic [7:0] c_load_m = tcr_mask(C_TCR_LOAD_BIT);
  localparam logic [7:0] c_en_m   = tcr_mask(C_TCR_EN_BIT);

  seq_state_t r_state;
  seq_state_t w_next;

  logic [7:0] r_tcr;
  logic [7:0] r_num;
  logic       r_stop_pend;
  logic       r_busy;
  logic       r_done;
  logic       r_event_pulse;
  logic [7:0] r_event_count;
  logic       r_err;

  logic       w_req;
  logic [7:0] w_addr;
  logic [7:0] w_wdata;
  logic       w_write;
  logic       w_ack;
  logic [7:0] w_rdata;
  logic       w_slverr;
  logic       w_timeout;
  logic       w_accept;
  logic       w_event;
  logic       w_xfer;
  logic       w_limit;
  logic       w_stop_pend;

  apb_master_if #(
    .TO_CYCLES (TO_CYCLES)
  ) u_apb (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .req     (w_req),
    .addr    (w_addr),
    .wdata   (w_wdata),
    .write   (w_write),
    .ack     (w_ack),
    .rdata   (w_rdata),
    .slverr  (w_slverr),
    .timeout (w_timeout),
    .bus     (m_apb)
  );

  assign w_xfer = r_state inside {ST_WR_TDR, ST_WR_TCR_LD, ST_WR_TCR_RUN,
                                  ST_POLL, ST_CLR, ST_WR_TCR_OFF};

  assign w_limit = (r_num != 8'h00) && (r_event_count == r_num);

  // A stop arriving in the very cycle of the decision still counts.
  assign w_stop_pend = r_stop_pend | stop;

  // Next state plus the request for the transfer belonging to that state.
  // The request is raised on the transition so the engine's SETUP phase
  // coincides with the first cycle of the new state.
  always_comb begin
    w_next   = r_state;
    w_req    = 1'b0;
    w_addr   = 8'h00;
    w_wdata  = 8'h00;
    w_write  = 1'b0;
    w_accept = 1'b0;
    w_event  = 1'b0;

    if (w_xfer && (w_timeout || w_slverr)) begin
      w_next = ST_ERR;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_accept = 1'b1;
            w_next   = ST_WR_TDR;
            w_req    = 1'b1;
            w_addr   = TDR_ADDR;
            w_wdata  = cfg_tdr;
            w_write  = 1'b1;
          end
        end
        ST_WR_TDR: begin
          if (w_ack) begin
            w_next  = ST_WR_TCR_LD;
            w_req   = 1'b1;
            w_addr  = TCR_ADDR;
            w_wdata = r_tcr | c_load_m;
            w_write = 1'b1;
          end
        end
        ST_WR_TCR_LD: begin
          if (w_ack) begin
            w_next  = ST_WR_TCR_RUN;
            w_req   = 1'b1;
            w_addr  = TCR_ADDR;
            w_wdata = r_tcr & ~c_load_m;
            w_write = 1'b1;
          end
        end
        ST_WR_TCR_RUN: begin
          if (w_ack) begin
            w_next = ST_POLL;
            w_req  = 1'b1;
            w_addr = TSR_ADDR;
          end
        end
        ST_POLL: begin
          if (w_ack) begin
            w_req = 1'b1;
            if ((w_rdata & C_TSR_FLAG_MASK) != 8'h00) begin
              w_event = 1'b1;
              w_next  = ST_CLR;
              w_addr  = TSR_ADDR;
              w_wdata = 8'h00;
              w_write = 1'b1;
            end else begin
              w_next = ST_POLL;
              w_addr = TSR_ADDR;
            end
          end
        end
        ST_CLR: begin
          if (w_ack) begin
            w_req = 1'b1;
            if (w_limit || w_stop_pend) begin
              w_next  = ST_WR_TCR_OFF;
              w_addr  = TCR_ADDR;
              w_wdata = r_tcr & ~(c_load_m | c_en_m);
              w_write = 1'b1;
            end else begin
              w_next = ST_POLL;
              w_addr = TSR_ADDR;
            end
          end
        end
        ST_WR_TCR_OFF: begin
          if (w_ack) begin
            w_next = ST_DONE;
          end
        end
        ST_DONE: w_next = ST_IDLE;
        ST_ERR:  w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state       <= ST_IDLE;
      r_tcr         <= 8'h00;
      r_num         <= 8'h00;
      r_stop_pend   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_event_pulse <= 1'b0;
      r_event_count <= 8'h00;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_busy        <= (w_next != ST_IDLE);
      r_done        <= (w_next == ST_DONE);
      r_event_pulse <= w_event;
      if (w_accept) begin
        // Stop in the accepting cycle is dropped along with the old state.
        r_tcr         <= cfg_tcr;
        r_num         <= num_events;
        r_event_count <= 8'h00;
        r_err         <= 1'b0;
        r_stop_pend   <= 1'b0;
      end else begin
        if (w_event) begin
          r_event_count <= r_event_count + 8'd1;
        end
        if (w_next == ST_ERR) begin
          r_err <= 1'b1;
        end
        if (stop && (r_state != ST_IDLE)) begin
          r_stop_pend <= 1'b1;
        end
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign event_pulse = r_event_pulse;
  assign event_count = r_event_count;
  assign err         = r_err;

endmodule : timer_apb_sequencer
`default_nettype wire

// File: tb/tb_timer_apb_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_apb_sequencer
// Description : Self-checking bench for timer_apb_sequencer. A small timer
//               slave model answers the APB bus; expected bus writes are
//               queued when a run is launched and matched as writes finish.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_apb_sequencer;

  localparam logic [7:0] c_tcr = 8'h00;
  localparam logic [7:0] c_tsr = 8'h01;
  localparam logic [7:0] c_tdr = 8'h02;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] cfg_tdr = 8'h00;
  logic [7:0] cfg_tcr = 8'h00;
  logic [7:0] num_events = 8'h00;
  logic       busy, done, event_pulse, err;
  logic [7:0] event_count;

  timer_apb_sequencer_if bus ();

  timer_apb_sequencer #(
    .TCR_ADDR  (c_tcr),
    .TSR_ADDR  (c_tsr),
    .TDR_ADDR  (c_tdr),
    .TO_CYCLES (16)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .start       (start),
    .stop        (stop),
    .cfg_tdr     (cfg_tdr),
    .cfg_tcr     (cfg_tcr),
    .num_events  (num_events),
    .busy        (busy),
    .done        (done),
    .event_pulse (event_pulse),
    .event_count (event_count),
    .err         (err),
    .m_apb       (bus)
  );

  always #5 PCLK = ~PCLK;

  // Slave model state
  logic [7:0] tsr = 8'h00;
  logic       s_pready = 1'b1;
  logic       s_pslverr = 1'b0;
  assign bus.M_PRDATA  = tsr;
  assign bus.M_PREADY  = s_pready;
  assign bus.M_PSLVERR = s_pslverr;

  logic        force_low = 1'b0;
  logic        arm_err = 1'b0;
  logic        arm_stall = 1'b0;
  int          stalls_left = 0;
  logic        track_ld = 1'b0;
  logic [16:0] ld_snap = '0;
  int          ld_cnt = 0;
  int          stable_err = 0;

  logic [15:0] exp_q[$];
  logic        exp_pulse = 1'b0;
  int          pulse_cnt = 0;
  int          done_cnt = 0;
  int          psel_cnt = 0;

  int n_tests = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Slave response and bus monitor; evaluated at the falling edge so the
  // values seen are the ones the DUT samples at the next rising edge.
  task automatic monitor_step();
    logic [15:0] e;
    if (!PRESETn) begin
      exp_pulse   = 1'b0;
      s_pready    = 1'b1;
      s_pslverr   = 1'b0;
      stalls_left = 0;
      track_ld    = 1'b0;
      return;
    end
    if (exp_pulse || event_pulse) check_val("event_pulse", event_pulse, exp_pulse);
    exp_pulse = 1'b0;
    if (event_pulse) pulse_cnt++;
    if (done) done_cnt++;
    if (bus.M_PSEL) psel_cnt++;

    s_pslverr = 1'b0;
    if (bus.M_PSEL && bus.M_PENABLE) begin
      if (stalls_left > 0) begin
        s_pready = 1'b0;
        stalls_left--;
      end else begin
        s_pready = !force_low;
      end
      if (arm_err && bus.M_PADDR == c_tdr) s_pslverr = 1'b1;
      if (track_ld) begin
        ld_cnt++;
        if ({bus.M_PWRITE, bus.M_PADDR, bus.M_PWDATA} != ld_snap) stable_err++;
      end
      if (s_pready) begin
        if (bus.M_PWRITE) begin
          if (exp_q.size() == 0) begin
            check_val("wr_q_nonempty", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check_val("apb_wr", {bus.M_PADDR, bus.M_PWDATA}, e);
          end
          if (bus.M_PADDR == c_tsr) tsr = bus.M_PWDATA;
        end else if (bus.M_PADDR == c_tsr && (tsr & 8'h03) != 8'h00) begin
          exp_pulse = 1'b1;
        end
        if (s_pslverr) arm_err = 1'b0;
        track_ld = 1'b0;
      end
    end else begin
      s_pready = 1'b1;
    end

    if (bus.M_PSEL && !bus.M_PENABLE && bus.M_PWRITE && bus.M_PADDR == c_tcr &&
        bus.M_PWDATA[7] && arm_stall) begin
      arm_stall   = 1'b0;
      stalls_left = 3;
      track_ld    = 1'b1;
      ld_snap     = {bus.M_PWRITE, bus.M_PADDR, bus.M_PWDATA};
    end
  endtask

  // One clock: monitor at the falling edge, return 1 time unit after the
  // rising edge where stimulus is changed and outputs are sampled.
  task automatic cycle();
    @(negedge PCLK);
    monitor_step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic launch(input logic [7:0] tdr, input logic [7:0] tcr,
                        input logic [7:0] n);
    exp_q.push_back({c_tdr, tdr});
    exp_q.push_back({c_tcr, tcr | 8'h80});
    exp_q.push_back({c_tcr, tcr & 8'h7F});
    cfg_tdr = tdr;
    cfg_tcr = tcr;
    num_events = n;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic wait_pulse(input string tag);
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (event_pulse) break;
    end
    check_val(tag, event_pulse, 1'b1);
  endtask

  task automatic inject_event(input logic [7:0] flag, input logic last,
                              input logic [7:0] off_val);
    exp_q.push_back({c_tsr, 8'h00});
    if (last) exp_q.push_back({c_tcr, off_val});
    tsr = flag;
    wait_pulse("evt_seen");
    for (int i = 0; i < 20 && tsr != 8'h00; i++) cycle();
    check_val("tsr_cleared", tsr, 8'h00);
  endtask

  task automatic wait_done(input string tag);
    int base;
    base = done_cnt;
    for (int i = 0; i < 40 && done_cnt == base; i++) cycle();
    check_val(tag, done_cnt - base, 1);
    check_val({tag, "_busy"}, busy, 1'b0);
    check_val({tag, "_done_w"}, done, 1'b0);
  endtask

  initial begin
    int pbase;
    int acc;

    repeat (3) cycle();
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_pulse", event_pulse, 1'b0);
    check_val("rst_count", event_count, 8'h00);
    check_val("rst_err", err, 1'b0);
    check_val("rst_psel", bus.M_PSEL, 1'b0);
    check_val("rst_penable", bus.M_PENABLE, 1'b0);
    check_val("rst_pwrite", bus.M_PWRITE, 1'b0);
    check_val("rst_paddr", bus.M_PADDR, 8'h00);
    check_val("rst_pwdata", bus.M_PWDATA, 8'h00);
    PRESETn = 1'b1;
    repeat (2) cycle();

    // Basic run: two events then auto-stop
    pbase = pulse_cnt;
    launch(8'hF0, 8'h30, 8'd2);
    check_val("t1_setup_psel", bus.M_PSEL, 1'b1);
    check_val("t1_setup_pen", bus.M_PENABLE, 1'b0);
    check_val("t1_setup_addr", bus.M_PADDR, c_tdr);
    check_val("t1_busy", busy, 1'b1);
    cycle();
    check_val("t1_access_pen", bus.M_PENABLE, 1'b1);
    repeat (6) cycle();
    inject_event(8'h01, 1'b0, 8'h00);
    inject_event(8'h01, 1'b1, 8'h20);
    wait_done("t1_done");
    check_val("t1_count", event_count, 8'd2);
    check_val("t1_pulses", pulse_cnt - pbase, 2);
    check_val("t1_q_empty", exp_q.size(), 0);

    // PREADY stall on the load write
    arm_stall = 1'b1;
    ld_cnt = 0;
    stable_err = 0;
    launch(8'hA5, 8'h31, 8'd1);
    repeat (8) cycle();
    inject_event(8'h02, 1'b1, 8'h21);
    wait_done("t2_done");
    check_val("t2_ld_access", ld_cnt, 4);
    check_val("t2_stable", stable_err, 0);
    check_val("t2_q_empty", exp_q.size(), 0);

    // Run-until-stop: five events, stop after the fifth
    pbase = pulse_cnt;
    launch(8'h10, 8'h33, 8'd0);
    repeat (6) cycle();
    for (int k = 0; k < 4; k++) inject_event(8'h01, 1'b0, 8'h00);
    check_val("t3_not_done", busy, 1'b1);
    exp_q.push_back({c_tsr, 8'h00});
    exp_q.push_back({c_tcr, 8'h23});
    tsr = 8'h02;
    wait_pulse("t3_evt5");
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    wait_done("t3_done");
    check_val("t3_count", event_count, 8'd5);
    check_val("t3_pulses", pulse_cnt - pbase, 5);
    check_val("t3_q_empty", exp_q.size(), 0);

    // PSLVERR on the TDR write, then recovery via a fresh start
    arm_err = 1'b1;
    exp_q.push_back({c_tdr, 8'h77});
    cfg_tdr = 8'h77;
    cfg_tcr = 8'h30;
    num_events = 8'd1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 20 && !err; i++) cycle();
    check_val("t4_err", err, 1'b1);
    cycle();
    check_val("t4_busy", busy, 1'b0);
    pbase = psel_cnt;
    repeat (10) cycle();
    check_val("t4_no_psel", psel_cnt - pbase, 0);
    check_val("t4_err_sticky", err, 1'b1);
    launch(8'h55, 8'h30, 8'd1);
    check_val("t4_err_clr", err, 1'b0);
    repeat (6) cycle();
    inject_event(8'h01, 1'b1, 8'h20);
    wait_done("t4_done");
    check_val("t4_q_empty", exp_q.size(), 0);

    // Reset during a POLL access
    launch(8'h11, 8'h30, 8'd0);
    repeat (6) cycle();
    inject_event(8'h01, 1'b0, 8'h00);
    check_val("t5_count_pre", event_count, 8'd1);
    for (int i = 0; i < 20; i++) begin
      if (bus.M_PSEL && bus.M_PENABLE && !bus.M_PWRITE && bus.M_PADDR == c_tsr) break;
      cycle();
    end
    check_val("t5_in_poll", bus.M_PENABLE, 1'b1);
    PRESETn = 1'b0;
    cycle();
    check_val("t5_psel", bus.M_PSEL, 1'b0);
    check_val("t5_penable", bus.M_PENABLE, 1'b0);
    check_val("t5_busy", busy, 1'b0);
    check_val("t5_count", event_count, 8'h00);
    PRESETn = 1'b1;
    cycle();
    check_val("t5_q_empty", exp_q.size(), 0);

    // PREADY stuck low
    force_low = 1'b1;
    cfg_tdr = 8'h42;
    cfg_tcr = 8'h30;
    num_events = 8'd1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    acc = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (bus.M_PSEL && bus.M_PENABLE) acc++;
      if (err) break;
    end
`ifdef TIMER_SEQ_TIMEOUT_EN
    check_val("t6_to_cycles", acc, 16);
    check_val("t6_err", err, 1'b1);
    check_val("t6_psel", bus.M_PSEL, 1'b0);
`else
    check_val("t6_no_err", err, 1'b0);
    check_val("t6_waiting", bus.M_PENABLE, 1'b1);
    check_val("t6_busy", busy, 1'b1);
`endif
    PRESETn = 1'b0;
    force_low = 1'b0;
    cycle();
    PRESETn = 1'b1;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_timer_apb_sequencer
`default_nettype wire
